// File: rtl/thor2023_dcache_victim_buf_pkg.sv
// Shared types for the data-cache victim buffer: line layout, queue entry and head-side FSM states.
package thor2023_dcache_victim_buf_pkg;

  localparam int WbAdrW         = 32;
  localparam int AsidW          = 8;
  localparam int LineDataW      = 512;
  localparam int DCacheTagLoBit = 6;
  localparam int LineKeyW       = WbAdrW - DCacheTagLoBit;

  typedef logic [WbAdrW-1:0] wb_address_t;

  typedef struct packed {
    wb_address_t          vtag;
    logic [AsidW-1:0]     asid;
    logic [LineDataW-1:0] data;
  } DCacheLine;

  typedef struct packed {
    logic      valid;
    DCacheLine line;
  } DCacheVictim_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } victim_state_t;

endpackage

// File: rtl/thor2023_dcache_victim_buf_if.sv
// Bus between the cache array / load path (master) and the victim buffer (slave).
interface thor2023_dcache_victim_buf_if #(
  parameter int DEPTH = 4
);
  import thor2023_dcache_victim_buf_pkg::*;

  // Handshakes: an evict transfers on the cycle evict_v & evict_rdy are both high, evict_rdy
  // depends only on buffer occupancy; dump stays high with dump_o stable until a one-cycle
  // dump_ack pops the head; lookup_v is a single-cycle request answered on the next cycle.
  logic                   evict_v;
  DCacheLine              evict_line;
  logic                   evict_rdy;
  logic                   dump;
  DCacheLine              dump_o;
  logic                   dump_ack;
  logic                   lookup_v;
  wb_address_t            lookup_adr;
  logic                   lookup_hit;
  logic [LineDataW-1:0]   lookup_dat;
  logic [$clog2(DEPTH):0] count;
  logic                   ovf_err;

  modport master (
    output evict_v, evict_line, dump_ack, lookup_v, lookup_adr,
    input  evict_rdy, dump, dump_o, lookup_hit, lookup_dat, count, ovf_err
  );

  modport slave (
    input  evict_v, evict_line, dump_ack, lookup_v, lookup_adr,
    output evict_rdy, dump, dump_o, lookup_hit, lookup_dat, count, ovf_err
  );

endinterface

// File: rtl/thor2023_dcache_victim_buf_match.sv
// DEPTH-way key comparator; scans oldest to youngest so the youngest valid match wins.
module thor2023_dcache_victim_buf_match #(
  parameter int DEPTH = 4,
  parameter int KW    = 26
) (
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [DEPTH-1:0][KW-1:0]   key_i,
  input  logic [KW-1:0]              probe_i,
  input  logic [$clog2(DEPTH)-1:0]   oldest_i,
  output logic                       hit_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] slot;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = oldest_i + PW'(k);
      if (valid_i[slot] && (key_i[slot] == probe_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/thor2023_dcache_victim_buf.sv
// Victim buffer: circular queue of evicted dirty lines, offered one at a time to the dump path,
// with in-place coalescing of re-evicted lines and a registered forwarding lookup.
module thor2023_dcache_victim_buf
  import thor2023_dcache_victim_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CID   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  thor2023_dcache_victim_buf_if.slave bus,
  output victim_state_t               state_o,
  output logic [7:0]                  lookup_cid_o
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CKW = AsidW + LineKeyW;

  DCacheVictim_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  victim_state_t             state_q, state_d;
  DCacheLine                 dump_o_q, dump_o_d;
  logic                      lookup_hit_q, lookup_hit_d;
  logic [LineDataW-1:0]      lookup_dat_q, lookup_dat_d;
  logic                      ovf_err_q, ovf_err_d;

  logic [DEPTH-1:0]                valid_vec, coal_mask;
  logic [DEPTH-1:0][CKW-1:0]       coal_keys;
  logic [DEPTH-1:0][LineKeyW-1:0]  lk_keys;
  logic                            coal_hit, lk_hit;
  logic [PW-1:0]                   coal_idx, lk_idx;
  logic                            accept, coalesce, push, pop;
  logic                            unused_adr_lo;

  always_comb begin
    valid_vec = '0;
    coal_keys = '0;
    lk_keys   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      coal_keys[i] = {entries_q[i].line.asid, entries_q[i].line.vtag[WbAdrW-1:DCacheTagLoBit]};
      lk_keys[i]   = entries_q[i].line.vtag[WbAdrW-1:DCacheTagLoBit];
    end
  end

  // The head is mid-transfer and must not change under the controller, so it never coalesces.
  assign coal_mask = valid_vec & ~(DEPTH'(1) << rd_ptr_q);

  thor2023_dcache_victim_buf_match #(.DEPTH(DEPTH), .KW(CKW)) u_coal_match (
    .valid_i  (coal_mask),
    .key_i    (coal_keys),
    .probe_i  ({bus.evict_line.asid, bus.evict_line.vtag[WbAdrW-1:DCacheTagLoBit]}),
    .oldest_i (rd_ptr_q),
    .hit_o    (coal_hit),
    .idx_o    (coal_idx)
  );

  thor2023_dcache_victim_buf_match #(.DEPTH(DEPTH), .KW(LineKeyW)) u_lookup_match (
    .valid_i  (valid_vec),
    .key_i    (lk_keys),
    .probe_i  (bus.lookup_adr[WbAdrW-1:DCacheTagLoBit]),
    .oldest_i (rd_ptr_q),
    .hit_o    (lk_hit),
    .idx_o    (lk_idx)
  );

  assign unused_adr_lo = ^bus.lookup_adr[DCacheTagLoBit-1:0];

  assign accept   = bus.evict_v & bus.evict_rdy;
  assign coalesce = accept & (state_q == OFFER) & coal_hit;
  assign push     = accept & ~coalesce;
  assign pop      = bus.dump_ack & (state_q == OFFER);

  always_comb begin
    entries_d    = entries_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    state_d      = state_q;
    dump_o_d     = dump_o_q;
    ovf_err_d    = ovf_err_q | (bus.evict_v & ~bus.evict_rdy) |
                   (bus.dump_ack & (state_q != OFFER));
    lookup_hit_d = bus.lookup_v & lk_hit;
    lookup_dat_d = (bus.lookup_v & lk_hit) ? entries_q[lk_idx].line.data : '0;

    if (coalesce) begin
      entries_d[coal_idx].line = bus.evict_line;
    end
    if (pop) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      entries_d[wr_ptr_q].valid = 1'b1;
      entries_d[wr_ptr_q].line  = bus.evict_line;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    case (state_q)
      EMPTY: begin
        if (count_q != '0) begin
          state_d  = OFFER;
          dump_o_d = entries_q[rd_ptr_q].line;
        end
      end
      OFFER: begin
        if (pop) state_d = GAP;
      end
      GAP: begin
        if (count_q != '0) begin
          state_d  = OFFER;
          dump_o_d = entries_q[rd_ptr_q].line;
        end else begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      entries_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= EMPTY;
      dump_o_q     <= '0;
      lookup_hit_q <= 1'b0;
      lookup_dat_q <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      entries_q    <= entries_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      dump_o_q     <= dump_o_d;
      lookup_hit_q <= lookup_hit_d;
      lookup_dat_q <= lookup_dat_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign bus.evict_rdy  = (count_q != CW'(DEPTH));
  assign bus.dump       = (state_q == OFFER);
  assign bus.dump_o     = dump_o_q;
  assign bus.lookup_hit = lookup_hit_q;
  assign bus.lookup_dat = lookup_dat_q;
  assign bus.count      = count_q;
  assign bus.ovf_err    = ovf_err_q;
  assign state_o        = state_q;
  assign lookup_cid_o   = lookup_hit_q ? 8'(CID) : 8'h00;

endmodule

// File: tb/tb_thor2023_dcache_victim_buf.sv
// Directed bench for the victim buffer: fill/drain, overflow, coalescing, lookup and async reset.
module tb_thor2023_dcache_victim_buf;
  import thor2023_dcache_victim_buf_pkg::*;

  typedef logic [$bits(DCacheLine)-1:0] w_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  victim_state_t state_o;
  logic [7:0]    lookup_cid_o;
  int            total = 0;
  int            bad   = 0;

  thor2023_dcache_victim_buf_if #(.DEPTH(4)) bus ();

  thor2023_dcache_victim_buf #(.DEPTH(4), .CID(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .state_o      (state_o),
    .lookup_cid_o (lookup_cid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic DCacheLine mk(input logic [31:0] vtag, input logic [31:0] seed);
    DCacheLine l;
    l.vtag = vtag;
    l.asid = 8'h01;
    l.data = {16{seed}};
    return l;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input int dmp, input int cnt);
    chk({tag, "_dump"},  w_t'(bus.dump),  w_t'(dmp));
    chk({tag, "_count"}, w_t'(bus.count), w_t'(cnt));
  endtask

  DCacheLine ln_a, ln_b, ln_c, ln_d, ln_e, ln_f, ln_b2, ln_a2;
  DCacheLine heads [3];

  initial begin
    ln_a  = mk(32'h0000_1000, 32'hA0A0_0001);
    ln_b  = mk(32'h0000_2000, 32'hB0B0_0002);
    ln_c  = mk(32'h0000_3000, 32'hC0C0_0003);
    ln_d  = mk(32'h0000_4000, 32'hD0D0_0004);
    ln_e  = mk(32'h0000_5000, 32'hE0E0_0005);
    ln_f  = mk(32'h0000_6000, 32'hF0F0_0006);
    ln_b2 = mk(32'h0000_2010, 32'hB2B2_0022);
    ln_a2 = mk(32'h0000_1008, 32'hA2A2_0011);
    heads[0] = ln_c;
    heads[1] = ln_d;
    heads[2] = ln_f;

    bus.evict_v    = 1'b0;
    bus.evict_line = '0;
    bus.dump_ack   = 1'b0;
    bus.lookup_v   = 1'b0;
    bus.lookup_adr = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    tick();
    chk_hs("rst", 0, 0);
    chk("rst_rdy",    w_t'(bus.evict_rdy),  w_t'(1));
    chk("rst_ovf",    w_t'(bus.ovf_err),    w_t'(0));
    chk("rst_dump_o", w_t'(bus.dump_o),     w_t'(0));
    chk("rst_hit",    w_t'(bus.lookup_hit), w_t'(0));
    chk("rst_state",  w_t'(state_o),        w_t'(EMPTY));

    // Single line A: stored, offered the following cycle, popped, one-cycle gap
    bus.evict_v = 1'b1; bus.evict_line = ln_a;
    tick();
    bus.evict_v = 1'b0;
    chk_hs("a_push", 0, 1);
    tick();
    chk_hs("a_offer", 1, 1);
    chk("a_dump_o", w_t'(bus.dump_o), w_t'(ln_a));
    bus.dump_ack = 1'b1;
    tick();
    bus.dump_ack = 1'b0;
    chk_hs("a_gap", 0, 0);
    chk("a_gap_state", w_t'(state_o), w_t'(GAP));
    tick();
    chk("a_empty_state", w_t'(state_o), w_t'(EMPTY));
    chk("a_ovf", w_t'(bus.ovf_err), w_t'(0));

    // Fill A,B,C,D then overflow with E
    bus.evict_v = 1'b1; bus.evict_line = ln_a; tick();
    bus.evict_line = ln_b; tick();
    chk("fill_offer_a", w_t'(bus.dump_o), w_t'(ln_a));
    bus.evict_line = ln_c; tick();
    bus.evict_line = ln_d; tick();
    chk_hs("full", 1, 4);
    chk("full_rdy", w_t'(bus.evict_rdy), w_t'(0));
    chk("full_ovf_clear", w_t'(bus.ovf_err), w_t'(0));
    bus.evict_line = ln_e; tick();
    chk_hs("ovf_push", 1, 4);
    chk("ovf_set", w_t'(bus.ovf_err), w_t'(1));

    // Full with ack and E together: no bypass at full, so E is dropped and only the pop lands
    bus.dump_ack = 1'b1;
    tick();
    bus.evict_v = 1'b0; bus.dump_ack = 1'b0;
    chk_hs("full_ack", 0, 3);
    tick();
    chk_hs("offer_b", 1, 3);
    chk("offer_b_dump_o", w_t'(bus.dump_o), w_t'(ln_b));

    // Lookup: hit inside C, lookup_v low, absent E
    bus.lookup_v = 1'b1; bus.lookup_adr = 32'h0000_3024;
    tick();
    chk("lk_c_hit", w_t'(bus.lookup_hit), w_t'(1));
    chk("lk_c_dat", w_t'(bus.lookup_dat), w_t'(ln_c.data));
    chk("lk_c_cid", w_t'(lookup_cid_o),   w_t'(2));
    bus.lookup_v = 1'b0;
    tick();
    chk("lk_idle_hit", w_t'(bus.lookup_hit), w_t'(0));
    bus.lookup_v = 1'b1; bus.lookup_adr = 32'h0000_5000;
    tick();
    bus.lookup_v = 1'b0;
    chk("lk_e_hit", w_t'(bus.lookup_hit), w_t'(0));
    chk("lk_e_dat", w_t'(bus.lookup_dat), w_t'(0));

    // Same-cycle push F and pop B: count unchanged
    bus.evict_v = 1'b1; bus.evict_line = ln_f; bus.dump_ack = 1'b1;
    tick();
    bus.evict_v = 1'b0; bus.dump_ack = 1'b0;
    chk_hs("pushpop", 0, 3);
    tick();

    // Drain C, D, F in order
    for (int i = 0; i < 3; i++) begin
      chk_hs("drain_offer", 1, 3 - i);
      chk("drain_dump_o", w_t'(bus.dump_o), w_t'(heads[i]));
      bus.dump_ack = 1'b1;
      tick();
      bus.dump_ack = 1'b0;
      chk_hs("drain_gap", 0, 2 - i);
      tick();
    end
    chk("drain_state", w_t'(state_o), w_t'(EMPTY));

    // Coalesce: A at head, B then B' merge; A' matches head so it is a normal push
    bus.evict_v = 1'b1; bus.evict_line = ln_a; tick();
    bus.evict_v = 1'b0; tick();
    chk("co_offer_a", w_t'(bus.dump_o), w_t'(ln_a));
    bus.evict_v = 1'b1; bus.evict_line = ln_b;  tick();
    bus.evict_line = ln_b2; tick();
    chk_hs("co_merge", 1, 2);
    bus.evict_line = ln_a2; tick();
    bus.evict_v = 1'b0;
    chk_hs("co_head_push", 1, 3);

    // Lookup in the pop cycle of A: youngest match A' reported
    bus.lookup_v = 1'b1; bus.lookup_adr = 32'h0000_1000; bus.dump_ack = 1'b1;
    tick();
    bus.lookup_v = 1'b0; bus.dump_ack = 1'b0;
    chk("co_lk_hit", w_t'(bus.lookup_hit), w_t'(1));
    chk("co_lk_dat", w_t'(bus.lookup_dat), w_t'(ln_a2.data));
    chk_hs("co_pop_a", 0, 2);
    tick();
    chk("co_offer_b2", w_t'(bus.dump_o), w_t'(ln_b2));

    // Entry popped in the lookup cycle is still reported
    bus.lookup_v = 1'b1; bus.lookup_adr = 32'h0000_2000; bus.dump_ack = 1'b1;
    tick();
    bus.lookup_v = 1'b0; bus.dump_ack = 1'b0;
    chk("prepop_hit", w_t'(bus.lookup_hit), w_t'(1));
    chk("prepop_dat", w_t'(bus.lookup_dat), w_t'(ln_b2.data));
    chk_hs("prepop_pop", 0, 1);
    tick();
    chk_hs("offer_a2", 1, 1);
    chk("offer_a2_dump_o", w_t'(bus.dump_o), w_t'(ln_a2));

    // Asynchronous reset mid-offer, then a stray ack
    rst_i = 1'b0;
    #1;
    chk_hs("arst", 0, 0);
    chk("arst_ovf",    w_t'(bus.ovf_err),   w_t'(0));
    chk("arst_dump_o", w_t'(bus.dump_o),    w_t'(0));
    chk("arst_rdy",    w_t'(bus.evict_rdy), w_t'(1));
    chk("arst_state",  w_t'(state_o),       w_t'(EMPTY));
    #2 rst_i = 1'b1;
    bus.dump_ack = 1'b1;
    tick();
    bus.dump_ack = 1'b0;
    chk_hs("stray_ack", 0, 0);
    chk("stray_ack_ovf", w_t'(bus.ovf_err), w_t'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
